// File: rtl/ro_freq_meter_pkg.sv
// Shared constants for the ring-oscillator frequency meter: register map,
// CTRL/STATUS bit positions, settle length and the measurement state encoding.
package ro_meter_pkg;

    // Word offsets decoded from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_GATE   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_SEL_LO = 4;
    localparam int CTRL_SEL_HI = 7;
    localparam int CTRL_CONT   = 8;
    localparam int CTRL_ABORT  = 9;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    // Cycles spent flushing the mux and synchroniser before a window opens
    localparam int SETTLE_CYCLES = 4;

    localparam logic [31:0] GATE_RESET = 32'd1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Wishbone slave bus bundle for the frequency meter.
interface ro_freq_meter_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ro_freq_meter_edge_sync.sv
// Brings the asynchronous ring-oscillator signal into the bus clock domain and
// emits a one-cycle pulse on each synchronised rising edge.
module ro_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    // Two synchroniser flops followed by one history flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/ro_freq_meter.sv
// Wishbone-mapped ring-oscillator frequency meter: register file, measurement
// FSM and saturating edge counter. The gate window register is kept at full
// bus width so narrow count registers can still be run over long windows.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    ro_freq_meter_if.slave   wbs,
    input  logic             ro_in,
    output logic [3:0]       ro_sel_o,
    output logic             busy_o,
    output logic             done_o
);
    logic             hit, rise;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d;
    logic             we_q;
    logic [1:0]       adr_q;
    logic [31:0]      wdat_q;
    logic [3:0]       wsel_q;
    logic             wr_fire, wr_ctrl, wr_gate, wr_stat, start_req, abort_req;
    logic             unused_adr;

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d, gate_q, gate_d;
    logic [CNT_W-1:0] live_q, live_d, count_q, count_d;
    logic             done_q, done_d, ovf_q, ovf_d, cont_q, cont_d;
    logic [3:0]       sel_q, sel_d;

    ro_edge_sync u_sync (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .async_i (ro_in),
        .rise_o  (rise)
    );

    assign unused_adr = ^wbs.wbs_adr_i[1:0];
    assign hit = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                 (wbs.wbs_adr_i[31:4] == ADDR_BASE[31:4]);

    // Single-cycle ack and registered read data, computed from current state
    always_comb begin
        ack_d  = hit & ~ack_q;
        rdat_d = '0;
        if (ack_d && !wbs.wbs_we_i) begin
            case (wbs.wbs_adr_i[3:2])
                REG_CTRL: begin
                    rdat_d[CTRL_SEL_HI:CTRL_SEL_LO] = sel_q;
                    rdat_d[CTRL_CONT]               = cont_q;
                end
                REG_GATE:  rdat_d = gate_q;
                REG_COUNT: rdat_d = 32'(count_q);
                default: begin
                    rdat_d[STAT_BUSY] = (state_q != ST_IDLE);
                    rdat_d[STAT_DONE] = done_q;
                    rdat_d[STAT_OVF]  = ovf_q;
                end
            endcase
        end
    end

    // Bus handshake; the write is captured with the request and applied during ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            wdat_q <= '0;
            wsel_q <= '0;
        end else begin
            ack_q  <= ack_d;
            rdat_q <= rdat_d;
            if (ack_d) begin
                we_q   <= wbs.wbs_we_i;
                adr_q  <= wbs.wbs_adr_i[3:2];
                wdat_q <= wbs.wbs_dat_i;
                wsel_q <= wbs.wbs_sel_i;
            end
        end
    end

    assign wr_fire   = ack_q & we_q;
    assign wr_ctrl   = wr_fire & (adr_q == REG_CTRL);
    assign wr_gate   = wr_fire & (adr_q == REG_GATE);
    assign wr_stat   = wr_fire & (adr_q == REG_STATUS);
    assign start_req = wr_ctrl & wsel_q[0] & wdat_q[CTRL_START];
    assign abort_req = wr_ctrl & wsel_q[1] & wdat_q[CTRL_ABORT];

    // Register writes then FSM; FSM updates come last so a set beats a W1C
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        live_d  = live_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        sel_d   = sel_q;
        cont_d  = cont_q;
        gate_d  = gate_q;

        if (wr_ctrl) begin
            if (wsel_q[0] && state_q == ST_IDLE) sel_d = wdat_q[CTRL_SEL_HI:CTRL_SEL_LO];
            if (wsel_q[1]) cont_d = wdat_q[CTRL_CONT];
        end
        if (wr_gate && state_q == ST_IDLE) begin
            for (int b = 0; b < 4; b++) begin
                if (wsel_q[b]) gate_d[8*b +: 8] = wdat_q[8*b +: 8];
            end
        end
        if (wr_stat && wsel_q[0]) begin
            if (wdat_q[STAT_DONE]) done_d = 1'b0;
            if (wdat_q[STAT_OVF])  ovf_d  = 1'b0;
        end

        if (abort_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                        live_d  = '0;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == 32'(SETTLE_CYCLES - 1)) begin
                        timer_d = '0;
                        state_d = (gate_q == '0) ? ST_DONE : ST_GATE;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                ST_GATE: begin
                    if (rise) begin
                        if (&live_q) ovf_d  = 1'b1;
                        else         live_d = live_q + CNT_W'(1);
                    end
                    if (timer_q == gate_q - 32'd1) begin
                        timer_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: begin
                    count_d = live_q;
                    done_d  = 1'b1;
                    if (cont_q) begin
                        live_d  = '0;
                        timer_d = '0;
                        state_d = (gate_q == '0) ? ST_DONE : ST_GATE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Measurement state and register file
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            live_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sel_q   <= '0;
            cont_q  <= 1'b0;
            gate_q  <= GATE_RESET;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            live_q  <= live_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
            cont_q  <= cont_d;
            gate_q  <= gate_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdat_q;
    assign ro_sel_o      = sel_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: a 32-bit and an 8-bit counter instance share the
// same bus stimulus; reads are scored against an expected-value queue.
module tb_ro_freq_meter;
    import ro_meter_pkg::*;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_CTL = BASE + 32'h0;
    localparam logic [31:0] A_GAT = BASE + 32'h4;
    localparam logic [31:0] A_CNT = BASE + 32'h8;
    localparam logic [31:0] A_STA = BASE + 32'hC;

    typedef struct packed { logic [31:0] lo; logic [31:0] hi; } exp_t;
    exp_t exp_q[$];

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic stb = 0, cyc = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] dat = 0, adr = 0;
    logic ro_in = 1'b0;
    int   ro_half = 0, ph = 0;
    bit   use_8 = 1'b0;
    int   tests = 0, fails = 0;

    ro_freq_meter_if bus32();
    ro_freq_meter_if bus8();
    assign bus32.wbs_stb_i = stb;  assign bus8.wbs_stb_i = stb;
    assign bus32.wbs_cyc_i = cyc;  assign bus8.wbs_cyc_i = cyc;
    assign bus32.wbs_we_i  = we;   assign bus8.wbs_we_i  = we;
    assign bus32.wbs_sel_i = sel;  assign bus8.wbs_sel_i = sel;
    assign bus32.wbs_dat_i = dat;  assign bus8.wbs_dat_i = dat;
    assign bus32.wbs_adr_i = adr;  assign bus8.wbs_adr_i = adr;

    logic [3:0] sel32, sel8;
    logic busy32, busy8, done32, done8;

    ro_freq_meter #(.CNT_W(32), .ADDR_BASE(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus32.slave), .ro_in(ro_in),
        .ro_sel_o(sel32), .busy_o(busy32), .done_o(done32));
    ro_freq_meter #(.CNT_W(8), .ADDR_BASE(BASE)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus8.slave), .ro_in(ro_in),
        .ro_sel_o(sel8), .busy_o(busy8), .done_o(done8));

    wire        ack_mon = use_8 ? bus8.wbs_ack_o : bus32.wbs_ack_o;
    wire [31:0] dat_mon = use_8 ? bus8.wbs_dat_o : bus32.wbs_dat_o;
    wire        done_mon = use_8 ? done8 : done32;

    // Ring oscillator model: toggles every ro_half clocks, offset from the edge
    always begin
        @(posedge clk);
        #2;
        if (ro_half == 0) begin
            ro_in = 1'b0;
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph >= ro_half) begin
                ph = 0;
                ro_in = ~ro_in;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int max_wait, output logic [31:0] rd,
                       output int t_ack, output bit acked, output bit one_cycle);
        @(negedge clk);
        adr = a; dat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        acked = 1'b0; one_cycle = 1'b0; t_ack = -1; rd = '0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (ack_mon === 1'b1) begin
                acked = 1'b1; t_ack = cyc_cnt; rd = dat_mon;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (acked) begin
            @(negedge clk);
            one_cycle = (ack_mon === 1'b0);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int t);
        logic [31:0] rd; bit acked, one;
        bus(1'b1, a, d, s, 20, rd, t, acked, one);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd, output int t,
                           output bit ok);
        bit acked, one;
        bus(1'b0, a, '0, 4'hF, 20, rd, t, acked, one);
        ok = acked & one;
    endtask

    task automatic wait_done(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_mon === 1'b1) begin
                t = cyc_cnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4] = '{A_CTL, A_GAT, A_CNT, A_STA};
        logic [31:0] vals  [4] = '{32'd0, 32'd1000, 32'd0, 32'd0};
        logic [31:0] rd; int t; bit ok; exp_t e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus32.wbs_ack_o, bus32.wbs_dat_o, sel32, busy32, done32} !== 39'd0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b dat=%h sel=%h busy=%b done=%b, all zero required",
                     bus32.wbs_ack_o, bus32.wbs_dat_o, sel32, busy32, done32);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{lo: vals[i], hi: vals[i]});
            wb_read(addrs[i], rd, t, ok);
            e = exp_q.pop_front();
            tests++;
            if (rd !== e.lo) begin
                fails++;
                $display("FAIL reset_read[%0d]: got %0d expected %0d", i, rd, e.lo);
            end
            tests++;
            if (ok !== 1'b1) begin
                fails++;
                $display("FAIL reset_ack[%0d]: got single-cycle ack=%b expected 1", i, ok);
            end
        end
    endtask

    task automatic test_measure();
        logic [31:0] rd; int t, td; bit ok; exp_t e;
        ro_half = 5;
        wb_write(A_GAT, 32'd1000, 4'hF, t);
        wb_write(A_CTL, 32'h51, 4'h1, t);
        tests++;
        if (sel32 !== 4'd5 || busy32 !== 1'b1) begin
            fails++;
            $display("FAIL measure_start: got sel=%0d busy=%b expected sel=5 busy=1", sel32, busy32);
        end
        wait_done(1200, td);
        tests++;
        if (td !== t + 1006) begin
            fails++;
            $display("FAIL measure_done_time: got %0d expected %0d", td, t + 1006);
        end
        tests++;
        if (busy32 !== 1'b0) begin
            fails++;
            $display("FAIL measure_busy_fall: got busy=%b expected 0", busy32);
        end
        exp_q.push_back('{lo: 32'd99, hi: 32'd100});
        wb_read(A_CNT, rd, t, ok);
        e = exp_q.pop_front();
        tests++;
        if ((rd >= e.lo && rd <= e.hi) !== 1'b1) begin
            fails++;
            $display("FAIL measure_count: got %0d expected %0d..%0d", rd, e.lo, e.hi);
        end
    endtask

    task automatic test_gate_zero();
        logic [31:0] rd; int t, td; bit ok; exp_t e;
        wb_write(A_GAT, 32'd0, 4'hF, t);
        wb_write(A_CTL, 32'h51, 4'h1, t);
        wait_done(50, td);
        tests++;
        if (td !== t + 6) begin
            fails++;
            $display("FAIL gate0_done_time: got %0d expected %0d", td, t + 6);
        end
        exp_q.push_back('{lo: 32'd0, hi: 32'd0});
        wb_read(A_CNT, rd, t, ok);
        e = exp_q.pop_front();
        tests++;
        if (rd !== e.lo) begin
            fails++;
            $display("FAIL gate0_count: got %0d expected %0d", rd, e.lo);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd; int t, td; bit ok; exp_t e;
        logic [31:0] addrs [5] = '{A_CNT, A_STA, A_CNT, A_STA, A_STA};
        bit          wide  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        ro_half = 2;
        wb_write(A_GAT, 32'd2000, 4'hF, t);
        wb_write(A_CTL, 32'h51, 4'h1, t);
        wait_done(2200, td);
        tests++;
        if (td !== t + 2006) begin
            fails++;
            $display("FAIL ovf_done_time: got %0d expected %0d", td, t + 2006);
        end
        exp_q.push_back('{lo: 32'd255, hi: 32'd255});
        exp_q.push_back('{lo: 32'h6, hi: 32'h6});
        exp_q.push_back('{lo: 32'd499, hi: 32'd500});
        exp_q.push_back('{lo: 32'h2, hi: 32'h2});
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                wb_write(A_STA, 32'h6, 4'h1, t);
                exp_q.push_back('{lo: 32'h0, hi: 32'h0});
            end
            use_8 = wide[i];
            wb_read(addrs[i], rd, t, ok);
            e = exp_q.pop_front();
            tests++;
            if ((rd >= e.lo && rd <= e.hi) !== 1'b1) begin
                fails++;
                $display("FAIL ovf_read[%0d] (cnt8=%0d): got %0d expected %0d..%0d",
                         i, wide[i], rd, e.lo, e.hi);
            end
        end
        use_8 = 1'b0;
    endtask

    task automatic test_continuous();
        logic [31:0] rd; int t, td; bit ok; exp_t e; bit fell;
        ro_half = 10;
        wb_write(A_GAT, 32'd200, 4'hF, t);
        wb_write(A_CTL, 32'h151, 4'h3, t);
        for (int w = 0; w < 3; w++) begin
            wait_done(400, td);
            exp_q.push_back('{lo: 32'd9, hi: 32'd11});
            wb_read(A_CNT, rd, t, ok);
            e = exp_q.pop_front();
            tests++;
            if ((rd >= e.lo && rd <= e.hi) !== 1'b1 || td < 0) begin
                fails++;
                $display("FAIL cont_window[%0d]: got %0d (done at %0d) expected %0d..%0d",
                         w, rd, td, e.lo, e.hi);
            end
            wb_write(A_STA, 32'h2, 4'h1, t);
        end
        wb_write(A_CTL, 32'h050, 4'h2, t);
        fell = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy32 === 1'b0) begin fell = 1'b1; break; end
        end
        tests++;
        if (fell !== 1'b1 || done32 !== 1'b1) begin
            fails++;
            $display("FAIL cont_stop: got busy_fell=%b done=%b expected 1 1", fell, done32);
        end
        repeat (250) @(negedge clk);
        tests++;
        if (busy32 !== 1'b0) begin
            fails++;
            $display("FAIL cont_stay_idle: got busy=%b expected 0", busy32);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int t, t1, td; bit ok; exp_t e;
        ro_half = 5;
        wb_write(A_GAT, 32'd0, 4'hF, t);
        wb_write(A_CTL, 32'h51, 4'h1, t);
        wait_done(50, td);
        wb_write(A_GAT, 32'd1000, 4'hF, t);
        wb_write(A_CTL, 32'h51, 4'h1, t);
        repeat (60) @(negedge clk);
        wb_write(A_CTL, 32'h200, 4'h2, t);
        tests++;
        if (busy32 !== 1'b0 || done32 !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: got busy=%b done=%b expected 0 0", busy32, done32);
        end
        exp_q.push_back('{lo: 32'd0, hi: 32'd0});
        exp_q.push_back('{lo: 32'd0, hi: 32'd0});
        wb_read(A_CNT, rd, t, ok);
        e = exp_q.pop_front();
        tests++;
        if (rd !== e.lo) begin
            fails++;
            $display("FAIL abort_count: got %0d expected %0d", rd, e.lo);
        end
        wb_read(A_STA, rd, t, ok);
        e = exp_q.pop_front();
        tests++;
        if (rd !== e.lo) begin
            fails++;
            $display("FAIL abort_status: got %h expected %h", rd, e.lo);
        end
        wb_write(A_CTL, 32'h51, 4'h1, t1);
        repeat (10) @(negedge clk);
        wb_write(A_CTL, 32'h31, 4'h1, t);
        tests++;
        if (sel32 !== 4'd5) begin
            fails++;
            $display("FAIL busy_sel_write: got sel=%0d expected 5", sel32);
        end
        exp_q.push_back('{lo: 32'h50, hi: 32'h50});
        wb_read(A_CTL, rd, t, ok);
        e = exp_q.pop_front();
        tests++;
        if (rd !== e.lo) begin
            fails++;
            $display("FAIL busy_ctrl_read: got %h expected %h", rd, e.lo);
        end
        wait_done(1200, td);
        tests++;
        if (td !== t1 + 1006) begin
            fails++;
            $display("FAIL busy_start_ignored: done at %0d expected %0d", td, t1 + 1006);
        end
        wb_write(A_CTL, 32'h251, 4'h3, t);
        repeat (3) @(negedge clk);
        tests++;
        if (busy32 !== 1'b0) begin
            fails++;
            $display("FAIL abort_beats_start: got busy=%b expected 0", busy32);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int t, acks, bad; bit acked, one; exp_t e;
        bus(1'b1, BASE + 32'h14, 32'd7, 4'hF, 5, rd, t, acked, one);
        tests++;
        if (acked !== 1'b0) begin
            fails++;
            $display("FAIL addr_miss_ack: got ack=%b expected 0", acked);
        end
        exp_q.push_back('{lo: 32'd1000, hi: 32'd1000});
        @(negedge clk);
        adr = A_GAT; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        acks = 0; bad = 0;
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_mon === 1'b1) begin
                acks++;
                if (dat_mon !== e.lo) bad++;
            end
        end
        stb = 1'b0; cyc = 1'b0;
        tests++;
        if (acks !== 4 || bad !== 0) begin
            fails++;
            $display("FAIL back_to_back: got %0d acks (%0d bad data) expected 4 acks of %0d",
                     acks, bad, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_measure();
        test_gate_zero();
        test_overflow();
        test_continuous();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
